// File: rtl/dct_transpose_8x8_if.sv
// Stream interface for the 8x8 transpose unit.
// One beat carries eight Width-bit coefficients plus block framing flags.
//   valid : beat valid (source to sink)
//   ready : sink accepts the beat when valid && ready
//   sof   : start of frame, marks beat 0 of a block
//   eol   : end of line, meaningful on beat 7 of a block
//   data  : eight coefficients, element [k] is column k (input) or row k (output)
// Modports: master drives the stream, slave consumes it.
interface dct_transpose_8x8_if #(
    parameter int unsigned Width = 14
) ();
    logic                   valid;
    logic                   ready;
    logic                   sof;
    logic                   eol;
    logic [7:0][Width-1:0]  data;

    modport master (output valid, output sof, output eol, output data, input ready);
    modport slave  (input valid, input sof, input eol, input data, output ready);
endinterface

// File: rtl/dct_transpose_8x8.sv
// Transpose unit placed after the column-DCT stage of the 2D DCT.
// Collects one 8x8 block as eight row beats and re-emits it column-major
// (output beat c carries column c). Two ping-pong banks let consecutive
// blocks stream at one beat per cycle in both directions.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   s   : input stream (slave), beat r carries row r
//   m   : output stream (master), beat c carries column c, element [j] = row j
//   err : one-cycle pulse when a partial block is discarded by a mid-block sof
module dct_transpose_8x8 #(
    parameter int unsigned Width = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    dct_transpose_8x8_if.slave     s,
    dct_transpose_8x8_if.master    m,
    output logic                   err
);
    typedef logic [7:0][Width-1:0] row_t;

    // Bank storage is deliberately not reset; validity lives in the full flags.
    row_t       mem_q [2][8];

    logic       wr_bank_q, wr_bank_d;
    logic [2:0] wr_cnt_q,  wr_cnt_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] rd_cnt_q,  rd_cnt_d;
    logic [1:0] full_q,    full_d;
    logic [1:0] sof_q,     sof_d;
    logic [1:0] eol_q,     eol_d;
    logic       err_q,     err_d;
    logic [2:0] wr_row;
    logic       s_acc;
    logic       m_acc;

    // Ready depends only on registered flags, so a bank freed this cycle
    // becomes writable on the next one.
    assign s.ready = !full_q[wr_bank_q];
    assign m.valid = full_q[rd_bank_q];
    assign m.sof   = m.valid && sof_q[rd_bank_q] && (rd_cnt_q == 3'd0);
    assign m.eol   = m.valid && eol_q[rd_bank_q] && (rd_cnt_q == 3'd7);
    assign err     = err_q;

    assign s_acc = s.valid && s.ready;
    assign m_acc = m.valid && m.ready;

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            m.data[j] = mem_q[rd_bank_q][j][rd_cnt_q];
        end
    end

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        full_d    = full_q;
        sof_d     = sof_q;
        eol_d     = eol_q;
        err_d     = 1'b0;
        wr_row    = wr_cnt_q;

        if (s_acc) begin
            if (s.sof && (wr_cnt_q != 3'd0)) begin
                // Resync: drop the rows gathered so far, restart the same bank.
                wr_row           = 3'd0;
                wr_cnt_d         = 3'd1;
                sof_d[wr_bank_q] = 1'b1;
                err_d            = 1'b1;
            end else begin
                if (wr_cnt_q == 3'd0) begin
                    sof_d[wr_bank_q] = s.sof;
                end
                if (wr_cnt_q == 3'd7) begin
                    eol_d[wr_bank_q]  = s.eol;
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = !wr_bank_q;
                    wr_cnt_d          = 3'd0;
                end else begin
                    wr_cnt_d = wr_cnt_q + 3'd1;
                end
            end
        end

        // Fill and drain always target different banks, so both may apply.
        if (m_acc) begin
            if (rd_cnt_q == 3'd7) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
                rd_cnt_d          = 3'd0;
            end else begin
                rd_cnt_d = rd_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= 3'd0;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= 3'd0;
            full_q    <= 2'b00;
            sof_q     <= 2'b00;
            eol_q     <= 2'b00;
            err_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            full_q    <= full_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s_acc) begin
            mem_q[wr_bank_q][wr_row] <= s.data;
        end
    end
endmodule

// File: tb/tb_dct_transpose_8x8.sv
// Directed bench for dct_transpose_8x8. A small reference model collects the
// accepted input rows and queues the transposed beats expected at the output.
module tb_dct_transpose_8x8;
    localparam int W = 14;

    typedef struct packed {
        logic                sof;
        logic                eol;
        logic [7:0][W-1:0]   data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic err;

    always #5 clk = ~clk;

    dct_transpose_8x8_if #(.Width(W)) s_if ();
    dct_transpose_8x8_if #(.Width(W)) m_if ();

    dct_transpose_8x8 #(.Width(W)) dut (
        .clk (clk),
        .rst (rst),
        .s   (s_if.slave),
        .m   (m_if.master),
        .err (err)
    );

    int checks = 0;
    int errors = 0;

    beat_t             exp_q[$];
    logic [7:0][W-1:0] rows [8];
    int                row_n = 0;
    logic              blk_sof = 1'b0;
    logic              blk_eol = 1'b0;
    int                acc_in = 0;
    int                acc_out = 0;

    bit stream_en = 1'b0;
    bit rand_mode = 1'b0;
    int cur_blk = 0;
    int cur_row = 0;

    function automatic logic [7:0][W-1:0] mk_row(int blk, int r);
        logic [7:0][W-1:0] v;
        for (int c = 0; c < 8; c++) v[c] = W'(blk * 128 + 16 * r + c);
        return v;
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive stream stimulus, update the model from the
    // handshakes visible before the edge, then advance to #1 after the edge.
    task automatic tick();
        beat_t e;
        if (stream_en) begin
            s_if.valid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            s_if.sof   = (cur_row == 0) && (cur_blk % 4 != 3);
            s_if.eol   = (cur_row == 7) && (cur_blk % 2 == 0);
            s_if.data  = mk_row(cur_blk, cur_row);
            if (rand_mode) m_if.ready = 1'($urandom_range(0, 1));
            #0;
        end
        if (rst) begin
            exp_q.delete();
            row_n = 0;
        end else begin
            if (s_if.valid && s_if.ready) begin
                acc_in++;
                if (s_if.sof) row_n = 0;
                if (row_n == 0) blk_sof = s_if.sof;
                rows[row_n] = s_if.data;
                if (row_n == 7) begin
                    blk_eol = s_if.eol;
                    for (int c = 0; c < 8; c++) begin
                        for (int j = 0; j < 8; j++) e.data[j] = rows[j][c];
                        e.sof = blk_sof && (c == 0);
                        e.eol = blk_eol && (c == 7);
                        exp_q.push_back(e);
                    end
                    row_n = 0;
                end else begin
                    row_n++;
                end
                if (stream_en) begin
                    cur_row++;
                    if (cur_row == 8) begin
                        cur_row = 0;
                        cur_blk++;
                    end
                end
            end
            if (m_if.valid && m_if.ready) begin
                acc_out++;
                chk("out_beat_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", m_if.data, e.data);
                    chk("out_sof", m_if.sof, e.sof);
                    chk("out_eol", m_if.eol, e.eol);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(int blk, int r, bit sof, bit eol);
        s_if.valid = 1'b1;
        s_if.sof   = sof;
        s_if.eol   = eol;
        s_if.data  = mk_row(blk, r);
        chk("send_ready", s_if.ready, 1);
        tick();
    endtask

    task automatic drain(int n);
        s_if.valid = 1'b0;
        s_if.sof   = 1'b0;
        s_if.eol   = 1'b0;
        m_if.ready = 1'b1;
        repeat (n) tick();
        chk("drained_queue", 128'(exp_q.size()), 128'(0));
        chk("drained_valid", m_if.valid, 0);
    endtask

    initial begin
        int base;
        int in_base;
        bit held;
        logic [7:0][W-1:0] hold;

        // Reset state
        rst        = 1'b1;
        s_if.valid = 1'b0;
        s_if.sof   = 1'b0;
        s_if.eol   = 1'b0;
        s_if.data  = '0;
        m_if.ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_m_valid", m_if.valid, 0);
        chk("rst_m_sof", m_if.sof, 0);
        chk("rst_m_eol", m_if.eol, 0);
        chk("rst_err", err, 0);
        chk("rst_s_ready", s_if.ready, 1);

        // Single block; stray eol on beat 3 must be ignored
        for (int r = 0; r < 8; r++) begin
            if (r == 7) chk("no_early_valid", m_if.valid, 0);
            send(0, r, r == 0, (r == 7) || (r == 3));
        end
        s_if.valid = 1'b0;
        chk("latency_valid", m_if.valid, 1);
        chk("latency_sof", m_if.sof, 1);
        chk("latency_eol", m_if.eol, 0);
        chk("first_col_elem1", 128'(m_if.data[1]), 128'(16));
        base = acc_out;
        drain(10);
        chk("single_block_beats", 128'(acc_out - base), 128'(8));

        // Four back-to-back blocks at full rate
        cur_blk   = 1;
        cur_row   = 0;
        stream_en = 1'b1;
        base      = acc_out;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) chk("stream_s_ready", s_if.ready, 1);
            tick();
        end
        stream_en = 1'b0;
        s_if.valid = 1'b0;
        chk("stream_out_so_far", 128'(acc_out - base), 128'(24));
        for (int i = 0; i < 8; i++) begin
            chk("stream_out_contig", m_if.valid, 1);
            tick();
        end
        chk("stream_out_total", 128'(acc_out - base), 128'(32));
        drain(4);

        // Output stall while streaming
        m_if.ready = 1'b0;
        stream_en  = 1'b1;
        in_base    = acc_in;
        held       = 1'b0;
        hold       = '0;
        repeat (20) begin
            tick();
            if (m_if.valid) begin
                if (!held) begin
                    hold = m_if.data;
                    held = 1'b1;
                end else begin
                    chk("stall_stable", m_if.data, hold);
                end
            end
        end
        chk("stall_accepted", 128'(acc_in - in_base), 128'(16));
        chk("stall_s_ready", s_if.ready, 0);
        chk("stall_m_valid", m_if.valid, 1);
        m_if.ready = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 40 && cur_row != 0; i++) tick();
        chk("stall_block_boundary", 128'(cur_row), 128'(0));
        stream_en = 1'b0;
        drain(24);

        // Random valid/ready over 20 blocks
        base      = cur_blk + 20;
        rand_mode = 1'b1;
        stream_en = 1'b1;
        for (int i = 0; i < 3000 && cur_blk < base; i++) tick();
        chk("random_done", 128'(cur_blk), 128'(base));
        stream_en = 1'b0;
        rand_mode = 1'b0;
        drain(24);

        // Resync: 3 rows then a new sof
        base = acc_out;
        send(40, 0, 1'b1, 1'b0);
        send(40, 1, 1'b0, 1'b0);
        send(40, 2, 1'b0, 1'b0);
        chk("resync_err_idle", err, 0);
        send(41, 0, 1'b1, 1'b0);
        chk("resync_err_pulse", err, 1);
        send(41, 1, 1'b0, 1'b0);
        chk("resync_err_once", err, 0);
        for (int r = 2; r < 8; r++) send(41, r, 1'b0, r == 7);
        s_if.valid = 1'b0;
        chk("resync_out_sof", m_if.sof, 1);
        drain(10);
        chk("resync_beats", 128'(acc_out - base), 128'(8));

        // Reset with one bank full and the other half written
        m_if.ready = 1'b0;
        for (int r = 0; r < 8; r++) send(50, r, r == 0, r == 7);
        for (int r = 0; r < 4; r++) send(51, r, r == 0, 1'b0);
        chk("pre_reset_valid", m_if.valid, 1);
        s_if.valid = 1'b0;
        rst        = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_reset_valid", m_if.valid, 0);
        chk("post_reset_s_ready", s_if.ready, 1);
        chk("post_reset_err", err, 0);
        m_if.ready = 1'b1;
        base = acc_out;
        for (int r = 0; r < 8; r++) send(52, r, r == 0, r == 7);
        drain(10);
        chk("post_reset_beats", 128'(acc_out - base), 128'(8));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
